// File: rtl/gate_exhaustive_checker.sv
// Exhaustive stimulus/response checker for small combinational gates: sweeps every
// input vector, samples the gate output after a settle time and compares it to TRUTH.
module gate_exhaustive_checker #(
  parameter int unsigned N_IN   = 2,
  parameter logic [255:0] TRUTH = 256'b1000,
  parameter int unsigned SETTLE = 2,
  parameter int unsigned ERR_W  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic [N_IN-1:0]  stim,
  input  logic             dut_out,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic [N_IN-1:0]  first_fail_vec,
  output logic             first_fail_valid
);

  localparam int unsigned CNT_W = (SETTLE < 2) ? 1 : $clog2(SETTLE + 1);

  typedef enum logic [1:0] {IDLE, DRIVE, CHECK, DONE} state_t;

  state_t           state;
  logic [CNT_W-1:0] settle_cnt;
  logic [7:0]       stim_idx;
  logic             mismatch;
  logic [ERR_W-1:0] err_next;

  always_comb begin
    stim_idx = 8'(stim);
    mismatch = (dut_out != TRUTH[stim_idx]);
    err_next = err_count;
    if (mismatch && (err_count != '1)) err_next = err_count + ERR_W'(1);
  end

  // The settle counter restarts at 0 after start but at 1 after each CHECK, so the
  // first vector gets one extra cycle to recover from the previous sweep's final stim.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= IDLE;
      stim             <= '0;
      busy             <= 1'b0;
      done             <= 1'b0;
      pass             <= 1'b0;
      err_count        <= '0;
      first_fail_vec   <= '0;
      first_fail_valid <= 1'b0;
      settle_cnt       <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state            <= DRIVE;
            stim             <= '0;
            busy             <= 1'b1;
            done             <= 1'b0;
            pass             <= 1'b0;
            err_count        <= '0;
            first_fail_vec   <= '0;
            first_fail_valid <= 1'b0;
            settle_cnt       <= '0;
          end
        end
        DRIVE: begin
          if (settle_cnt == CNT_W'(SETTLE)) state <= CHECK;
          else settle_cnt <= settle_cnt + CNT_W'(1);
        end
        CHECK: begin
          err_count <= err_next;
          if (mismatch && !first_fail_valid) begin
            first_fail_vec   <= stim;
            first_fail_valid <= 1'b1;
          end
          if (stim == '1) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (err_next == '0);
          end else begin
            stim       <= stim + N_IN'(1);
            state      <= DRIVE;
            settle_cnt <= CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gate_exhaustive_checker.sv
// Scoreboard bench for gate_exhaustive_checker driving a behavioural 2-input gate
// (correct AND, stuck-at-0, stuck-at-1), with a second instance at ERR_W=1.
module tb_gate_exhaustive_checker;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [1:0] stim, stim1;
  logic       dut_out, dut_out1;
  logic       busy, done, pass, ffval;
  logic       busy1, done1, pass1, ffval1;
  logic [7:0] err_count;
  logic [0:0] err_count1;
  logic [1:0] ffv, ffv1;
  int         mode = 0;
  int         cyc = 0;
  int         n_cmp = 0;
  int         n_bad = 0;

  typedef struct {
    int start_edge;
    int err;
    int ffv;
    int ffvalid;
    int pass;
    int err1;
  } rec_t;

  rec_t exp_q[$];

  gate_exhaustive_checker #(.N_IN(2), .TRUTH(256'b1000), .SETTLE(2), .ERR_W(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stim(stim), .dut_out(dut_out),
    .busy(busy), .done(done), .pass(pass), .err_count(err_count),
    .first_fail_vec(ffv), .first_fail_valid(ffval)
  );

  gate_exhaustive_checker #(.N_IN(2), .TRUTH(256'b1000), .SETTLE(2), .ERR_W(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .stim(stim1), .dut_out(dut_out1),
    .busy(busy1), .done(done1), .pass(pass1), .err_count(err_count1),
    .first_fail_vec(ffv1), .first_fail_valid(ffval1)
  );

  // mode 0: correct AND, 1: stuck-at-0, 2: stuck-at-1
  assign dut_out  = (mode == 0) ? (stim[0] & stim[1])   : (mode == 2);
  assign dut_out1 = (mode == 0) ? (stim1[0] & stim1[1]) : (mode == 2);

  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp = n_cmp + 1;
    if (act != exp) begin
      n_bad = n_bad + 1;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops one expectation per rising edge of done.
  logic done_prev = 1'b0;
  always @(negedge clk) begin
    if (!rst_n) begin
      done_prev = 1'b0;
    end else begin
      if (done && !done_prev) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          rec_t r;
          r = exp_q.pop_front();
          chk("done_edge", cyc - r.start_edge, 13);
          chk("err_count", int'(err_count), r.err);
          chk("first_fail_vec", int'(ffv), r.ffv);
          chk("first_fail_valid", int'(ffval), r.ffvalid);
          chk("pass", int'(pass), r.pass);
          chk("busy_at_done", int'(busy), 0);
          chk("final_stim", int'(stim), 3);
          chk("done_w1", int'(done1), 1);
          chk("err_count_w1", int'(err_count1), r.err1);
        end
      end
      done_prev = done;
    end
  end

  task automatic issue(input int m, input int e, input int fv, input int fval,
                       input int p, input int e1, output int s);
    rec_t r;
    @(negedge clk);
    mode  = m;
    start = 1'b1;
    @(posedge clk);
    #1;
    s = cyc;
    r.start_edge = s; r.err = e; r.ffv = fv; r.ffvalid = fval; r.pass = p; r.err1 = e1;
    exp_q.push_back(r);
    start = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 60 && exp_q.size() > 0; i++) @(negedge clk);
    if (exp_q.size() > 0) begin
      chk("timeout_waiting_done", exp_q.size(), 0);
      exp_q.delete();
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_stim"}, int'(stim), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_pass"}, int'(pass), 0);
    chk({tag, "_err"}, int'(err_count), 0);
    chk({tag, "_ffv"}, int'(ffv), 0);
    chk({tag, "_ffval"}, int'(ffval), 0);
    chk({tag, "_err_w1"}, int'(err_count1), 0);
  endtask

  initial begin
    int s;
    #3;
    chk_reset_outputs("por");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Correct AND with stim/busy trace: stim 0 for edges 0..3, then 3 edges per vector.
    issue(0, 0, 0, 0, 1, 0, s);
    for (int r = 0; r <= 12; r++) begin
      int es;
      @(negedge clk);
      es = (cyc - s <= 3) ? 0 : (cyc - s - 1) / 3;
      chk("trace_stim", int'(stim), es);
      chk("trace_busy", int'(busy), 1);
    end
    drain();

    // Stuck-at-0, then stuck-at-1.
    issue(1, 1, 3, 1, 0, 1, s);
    drain();
    issue(2, 3, 0, 1, 0, 1, s);
    drain();

    // Start pulses at relative edges 4 and 8 must be ignored.
    issue(0, 0, 0, 0, 1, 0, s);
    while (cyc < s + 3) @(negedge clk);
    start = 1'b1; @(negedge clk); start = 1'b0;
    while (cyc < s + 7) @(negedge clk);
    start = 1'b1; @(negedge clk); start = 1'b0;
    drain();
    repeat (5) @(negedge clk);
    chk("idle_after_done_busy", int'(busy), 0);
    chk("idle_after_done_done", int'(done), 1);

    // Asynchronous reset mid-sweep, then a fresh sweep.
    issue(2, 3, 0, 1, 0, 1, s);
    while (cyc < s + 6) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("midrst");
    void'(exp_q.pop_back());
    @(negedge clk);
    rst_n = 1'b1;
    issue(0, 0, 0, 0, 1, 0, s);
    drain();

    // Stuck-at-0 sweep followed by a correct sweep: second start clears results.
    issue(1, 1, 3, 1, 0, 1, s);
    drain();
    issue(0, 0, 0, 0, 1, 0, s);
    @(negedge clk);
    chk("restart_clears_err", int'(err_count), 0);
    chk("restart_clears_ffval", int'(ffval), 0);
    drain();

    // start held high: DONE lasts one cycle, next sweep starts on the following edge.
    begin
      rec_t r2;
      issue(0, 0, 0, 0, 1, 0, s);
      start = 1'b1;
      r2.start_edge = s + 14; r2.err = 0; r2.ffv = 0; r2.ffvalid = 0; r2.pass = 1; r2.err1 = 0;
      exp_q.push_back(r2);
      for (int i = 0; i < 40 && cyc < s + 13; i++) @(negedge clk);
      chk("held_done_high", int'(done), 1);
      @(negedge clk);
      chk("held_done_one_cycle", int'(done), 0);
      chk("held_restart_busy", int'(busy), 1);
      start = 1'b0;
      drain();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
